// File: rtl/ppi_bus_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : ppi_pkg
// Brief  : Shared types and constants for the 8255 PPI bus sequencer.
// Rev    : 1.0
// ============================================================================
package ppi_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } ppiState_t;

  localparam logic [1:0] PPI_PORT_A   = 2'b00;
  localparam logic [1:0] PPI_PORT_B   = 2'b01;
  localparam logic [1:0] PPI_PORT_C   = 2'b10;
  localparam logic [1:0] PPI_CTRL     = 2'b11;
  localparam logic [7:0] PPI_RESET_CW = 8'h9B;

  // Mode words have bit7 set; bit7 clear on the control address is a bit set/reset.
  function automatic logic isModeWord(input logic [1:0] addr, input logic [7:0] data);
    return (addr == PPI_CTRL) && data[7];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppi_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : ppi_bus_sequencer_if
// Brief  : Host-side request/completion bundle for the two PPI requesters.
// Rev    : 1.0
// ============================================================================
interface ppi_bus_sequencer_if;

  logic       req0;
  logic [1:0] addr0;
  logic       we0;
  logic [7:0] wdata0;
  logic       done0;
  logic       req1;
  logic [1:0] addr1;
  logic       we1;
  logic [7:0] wdata1;
  logic       done1;
  logic [7:0] rdata;

  modport master (
    output req0, addr0, we0, wdata0, req1, addr1, we1, wdata1,
    input  done0, done1, rdata
  );

  modport slave (
    input  req0, addr0, we0, wdata0, req1, addr1, we1, wdata1,
    output done0, done1, rdata
  );

endinterface
`default_nettype wire

// File: rtl/ppi_bus_sequencer_arb.sv
`default_nettype none
// ============================================================================
// Module : ppi_rr_arbiter
// Brief  : Two-way round-robin arbiter; the pointer moves on each grant strobe.
// Rev    : 1.0
// ============================================================================
module ppi_rr_arbiter (
  input  wire logic       clk,
  input  wire logic       Reset,
  input  wire logic [1:0] req,
  input  wire logic       grantStrobe,
  output logic            grantValid,
  output logic            grantIdx
);

  // Requester that wins when both ask at once.
  logic r_prio;

  always_comb begin
    grantValid = |req;
    grantIdx   = 1'b0;
    if (req[0] && req[1]) grantIdx = r_prio;
    else                  grantIdx = req[1];
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_prio <= 1'b0;
    end else if (grantStrobe && grantValid) begin
      r_prio <= ~grantIdx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ppi_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module : ppi_bus_sequencer
// Brief  : Arbitrates two requesters onto an 8255 PPI and times CS/address/strobes.
// Rev    : 1.0
// ============================================================================
module ppi_bus_sequencer #(
  parameter int         SETUP_CYC  = 1,
  parameter int         STROBE_CYC = 2,
  parameter int         HOLD_CYC   = 1,
  parameter bit         INIT_EN    = 1'b1,
  parameter logic [7:0] INIT_CW    = 8'h80
) (
  input  wire logic           clk,
  input  wire logic           Reset,
  ppi_bus_sequencer_if.slave  host,
  output logic                busy,
  output logic [7:0]          cw_shadow,
  output logic                cs_low,
  output logic                A0,
  output logic                A1,
  output logic                RD_low,
  output logic                WR_low,
  inout  wire logic [7:0]     data_buffer
);

  import ppi_pkg::*;

  localparam logic [3:0] c_setupLd  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] c_strobeLd = 4'(STROBE_CYC - 1);
  localparam logic [3:0] c_holdLd   = 4'(HOLD_CYC - 1);

  ppiState_t  r_state;
  ppiState_t  w_nextState;
  logic [3:0] r_cnt;
  logic [3:0] w_cntLoad;
  logic       w_cntZero;
  logic [1:0] r_addr;
  logic       r_we;
  logic [7:0] r_wdata;
  logic       r_owner;
  logic       r_isInit;
  logic [7:0] r_rdata;
  logic [7:0] r_cwShadow;
  logic       w_active;
  logic       w_drive;
  logic       w_grantValid;
  logic       w_grantIdx;
  logic       w_grantStrobe;

  ppi_rr_arbiter u_arb (
    .clk         (clk),
    .Reset       (Reset),
    .req         ({host.req1, host.req0}),
    .grantStrobe (w_grantStrobe),
    .grantValid  (w_grantValid),
    .grantIdx    (w_grantIdx)
  );

  assign w_cntZero     = (r_cnt == 4'd0);
  assign w_grantStrobe = (r_state == ST_IDLE) && w_grantValid;

  always_ff @(posedge clk) begin
    if (Reset) r_state <= INIT_EN ? ST_INIT : ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_cntLoad   = 4'd0;
    case (r_state)
      ST_INIT:   w_nextState = ST_SETUP;
      ST_IDLE:   if (w_grantValid) w_nextState = ST_SETUP;
      ST_SETUP:  if (w_cntZero) w_nextState = ST_STROBE;
      ST_STROBE: if (w_cntZero) w_nextState = ST_HOLD;
      ST_HOLD:   if (w_cntZero) w_nextState = ST_DONE;
      ST_DONE:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
    case (w_nextState)
      ST_SETUP:  w_cntLoad = c_setupLd;
      ST_STROBE: w_cntLoad = c_strobeLd;
      ST_HOLD:   w_cntLoad = c_holdLd;
      default:   w_cntLoad = 4'd0;
    endcase
  end

  always_comb begin
    w_active = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD);
    w_drive  = w_active && r_we;
    cs_low   = ~w_active;
    A1       = w_active & r_addr[1];
    A0       = w_active & r_addr[0];
    RD_low   = ~((r_state == ST_STROBE) && !r_we);
    WR_low   = ~((r_state == ST_STROBE) && r_we);
    busy     = (r_state != ST_IDLE);
  end

  // Init transactions borrow the datapath but never signal a requester.
  assign host.done0 = (r_state == ST_DONE) && !r_isInit && (r_owner == 1'b0);
  assign host.done1 = (r_state == ST_DONE) && !r_isInit && (r_owner == 1'b1);
  assign host.rdata = r_rdata;
  assign cw_shadow  = r_cwShadow;
  assign data_buffer = w_drive ? r_wdata : 8'hzz;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_cnt      <= 4'd0;
      r_addr     <= 2'b00;
      r_we       <= 1'b0;
      r_wdata    <= 8'h00;
      r_owner    <= 1'b0;
      r_isInit   <= 1'b0;
      r_rdata    <= 8'h00;
      r_cwShadow <= PPI_RESET_CW;
    end else begin
      if (w_nextState != r_state) r_cnt <= w_cntLoad;
      else if (!w_cntZero)        r_cnt <= r_cnt - 4'd1;

      if (r_state == ST_INIT) begin
        r_addr   <= PPI_CTRL;
        r_we     <= 1'b1;
        r_wdata  <= INIT_CW;
        r_isInit <= 1'b1;
      end else if (w_grantStrobe) begin
        r_addr   <= w_grantIdx ? host.addr1  : host.addr0;
        r_we     <= w_grantIdx ? host.we1    : host.we0;
        r_wdata  <= w_grantIdx ? host.wdata1 : host.wdata0;
        r_owner  <= w_grantIdx;
        r_isInit <= 1'b0;
      end

      if ((r_state == ST_STROBE) && w_cntZero && !r_we) r_rdata <= data_buffer;
      if ((r_state == ST_HOLD) && w_cntZero && r_we && isModeWord(r_addr, r_wdata))
        r_cwShadow <= r_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppi_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_ppi_bus_sequencer
// Brief  : Directed + random self-checking bench with a PPI device model.
// Rev    : 1.0
// ============================================================================
module tb_ppi_bus_sequencer;

  import ppi_pkg::*;

  localparam int         SETUP_CYC  = 1;
  localparam int         STROBE_CYC = 2;
  localparam int         HOLD_CYC   = 1;
  localparam logic [7:0] INIT_CW    = 8'h80;
  localparam int         CS_CYC     = SETUP_CYC + STROBE_CYC + HOLD_CYC;
  localparam int         LAT        = CS_CYC + 1;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       busy, cs_low, A0, A1, RD_low, WR_low;
  logic [7:0] cw_shadow;
  wire  [7:0] data_buffer;

  ppi_bus_sequencer_if hostIf();

  ppi_bus_sequencer #(
    .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC),
    .INIT_EN(1'b1), .INIT_CW(INIT_CW)
  ) dut (
    .clk(clk), .Reset(Reset), .host(hostIf), .busy(busy), .cw_shadow(cw_shadow),
    .cs_low(cs_low), .A0(A0), .A1(A1), .RD_low(RD_low), .WR_low(WR_low),
    .data_buffer(data_buffer)
  );

  always #5 clk = ~clk;

  // PPI device: drives its port register while read-strobed, latches data while write-strobed.
  logic [7:0] devReg [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};
  assign data_buffer = (!cs_low && !RD_low) ? devReg[{A1, A0}] : 8'hzz;

  // Reference model: what the host believes the device and shadow hold.
  logic [7:0] expReg [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};
  logic [7:0] expShadow;
  int         lastServed;

  int nTests = 0, nFail = 0;
  int cyc = 0, wrCnt = 0, rdCnt = 0, csCnt = 0, done0Cnt = 0, done1Cnt = 0;
  logic [1:0] lastWrAddr;
  logic [7:0] lastWrData;
  bit         chkOn = 0, chkWrite = 0;
  logic [7:0] chkData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
    if (!WR_low) begin
      wrCnt++;
      lastWrAddr = {A1, A0};
      lastWrData = data_buffer;
      devReg[{A1, A0}] = data_buffer;
    end
    if (!RD_low)       rdCnt++;
    if (!cs_low)       csCnt++;
    if (hostIf.done0)  done0Cnt++;
    if (hostIf.done1)  done1Cnt++;
    check("strobeExcl", 32'(RD_low | WR_low), 32'd1);
    if (cs_low) begin
      check("idleLines", {RD_low, WR_low, A1, A0}, 4'b1100);
      check("idleBusZ", data_buffer, 8'hzz);
    end else if (chkOn) begin
      if (chkWrite)     check("wrBusData", data_buffer, chkData);
      else if (RD_low)  check("rdSideZ", data_buffer, 8'hzz);
    end
  endtask

  task automatic doResetInit(input int holdCycles);
    int wr0, cs0, d0, d1;
    bit got;
    Reset = 1'b1;
    hostIf.req0 = 1'b0;
    hostIf.req1 = 1'b0;
    chkOn = 0;
    tick();
    check("rstLines", {cs_low, RD_low, WR_low, A1, A0}, 5'b11100);
    check("rstBusZ", data_buffer, 8'hzz);
    check("rstDone", {hostIf.done0, hostIf.done1}, 2'b00);
    check("rstRdata", hostIf.rdata, 8'h00);
    check("rstShadow", cw_shadow, PPI_RESET_CW);
    check("rstBusy", busy, 1'b1);
    for (int i = 1; i < holdCycles; i++) tick();
    wr0 = wrCnt; cs0 = csCnt; d0 = done0Cnt; d1 = done1Cnt;
    chkOn = 1; chkWrite = 1; chkData = INIT_CW;
    Reset = 1'b0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (!busy) got = 1;
    end
    check("initFinish", got, 1'b1);
    check("initWrWidth", wrCnt - wr0, STROBE_CYC);
    check("initCsWidth", csCnt - cs0, CS_CYC);
    check("initWrite", {lastWrAddr, lastWrData}, {PPI_CTRL, INIT_CW});
    check("initNoDone", (done0Cnt - d0) + (done1Cnt - d1), 0);
    expReg[PPI_CTRL] = INIT_CW;
    expShadow = PPI_RESET_CW;
    if (INIT_CW[7]) expShadow = INIT_CW;
    check("initShadow", cw_shadow, expShadow);
    lastServed = 1;
    chkOn = 0;
  endtask

  task automatic doTxn(input int who, input logic [1:0] a, input logic w, input logic [7:0] d);
    int  wr0, rd0, cs0, d0, d1, lat;
    bit  got, myDone;
    wr0 = wrCnt; rd0 = rdCnt; cs0 = csCnt; d0 = done0Cnt; d1 = done1Cnt;
    lat = 0; got = 0;
    chkOn = 1; chkWrite = w; chkData = d;
    if (who == 0) begin
      hostIf.req0 = 1'b1; hostIf.addr0 = a; hostIf.we0 = w; hostIf.wdata0 = d;
      hostIf.addr1 = 2'($urandom); hostIf.we1 = 1'($urandom); hostIf.wdata1 = 8'($urandom);
    end else begin
      hostIf.req1 = 1'b1; hostIf.addr1 = a; hostIf.we1 = w; hostIf.wdata1 = d;
      hostIf.addr0 = 2'($urandom); hostIf.we0 = 1'($urandom); hostIf.wdata0 = 8'($urandom);
    end
    for (int i = 1; i <= 30 && !got; i++) begin
      tick();
      myDone = (who == 0) ? hostIf.done0 : hostIf.done1;
      if (myDone) begin got = 1; lat = i; end
    end
    hostIf.req0 = 1'b0;
    hostIf.req1 = 1'b0;
    if (w) begin
      expReg[a] = d;
      if (a == PPI_CTRL && d[7]) expShadow = d;
    end
    check("doneSeen", got, 1'b1);
    check("latency", lat, LAT);
    check("otherDone", (who == 0) ? done1Cnt - d1 : done0Cnt - d0, 0);
    check("wrWidth", wrCnt - wr0, w ? STROBE_CYC : 0);
    check("rdWidth", rdCnt - rd0, w ? 0 : STROBE_CYC);
    check("csWidth", csCnt - cs0, CS_CYC);
    if (w) check("wrAddrData", {lastWrAddr, lastWrData}, {a, d});
    else   check("rdata", hostIf.rdata, expReg[a]);
    check("shadow", cw_shadow, expShadow);
    tick();
    check("donePulse", {hostIf.done0, hostIf.done1}, 2'b00);
    check("idleBusy", busy, 1'b0);
    lastServed = who;
    chkOn = 0;
  endtask

  initial begin
    int  expNext, who, lastDoneCyc;
    bit  got, found;
    logic [7:0] v0, v1, wd;
    hostIf.req0 = 1'b0; hostIf.addr0 = 2'b00; hostIf.we0 = 1'b0; hostIf.wdata0 = 8'h00;
    hostIf.req1 = 1'b0; hostIf.addr1 = 2'b00; hostIf.we1 = 1'b0; hostIf.wdata1 = 8'h00;

    doResetInit(2);

    doTxn(0, PPI_PORT_A, 1'b1, 8'h01);
    doTxn(1, PPI_PORT_C, 1'b0, 8'h00);
    check("portCRead", hostIf.rdata, 8'hA5);

    // Bit set/reset word must not disturb the shadow; a mode word must.
    doTxn(0, PPI_CTRL, 1'b1, 8'h07);
    check("bsrShadow", cw_shadow, 8'h80);
    doTxn(1, PPI_CTRL, 1'b1, 8'h9B);
    check("modeShadow", cw_shadow, 8'h9B);

    // Contention: both held, grants must alternate at the back-to-back period.
    v0 = 8'($urandom); v1 = 8'($urandom);
    hostIf.req0 = 1'b1; hostIf.addr0 = PPI_PORT_B; hostIf.we0 = 1'b1; hostIf.wdata0 = v0;
    hostIf.req1 = 1'b1; hostIf.addr1 = PPI_PORT_C; hostIf.we1 = 1'b1; hostIf.wdata1 = v1;
    expNext = (lastServed == 0) ? 1 : 0;
    lastDoneCyc = 0;
    for (int g = 0; g < 4; g++) begin
      got = 0; who = -1;
      for (int i = 0; i < 20 && !got; i++) begin
        tick();
        if (hostIf.done0 || hostIf.done1) begin got = 1; who = hostIf.done1 ? 1 : 0; end
      end
      check("ctnDone", got, 1'b1);
      check("ctnSingle", hostIf.done0 & hostIf.done1, 1'b0);
      check("ctnOrder", who, expNext);
      if (g > 0) check("ctnPeriod", cyc - lastDoneCyc, LAT + 1);
      lastDoneCyc = cyc;
      lastServed = who;
      expNext = (who == 0) ? 1 : 0;
    end
    hostIf.req0 = 1'b0;
    hostIf.req1 = 1'b0;
    expReg[PPI_PORT_B] = v0;
    expReg[PPI_PORT_C] = v1;
    tick();
    check("ctnIdle", busy, 1'b0);
    doTxn(0, PPI_PORT_B, 1'b0, 8'h00);
    doTxn(1, PPI_PORT_C, 1'b0, 8'h00);

    for (int n = 0; n < 20; n++)
      doTxn(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 8'($urandom));

    // Reset in the middle of a write strobe.
    wd = 8'($urandom);
    chkOn = 1; chkWrite = 1; chkData = wd;
    hostIf.req0 = 1'b1; hostIf.addr0 = PPI_PORT_A; hostIf.we0 = 1'b1; hostIf.wdata0 = wd;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (!WR_low) found = 1;
    end
    check("reachStrobe", found, 1'b1);
    expReg[PPI_PORT_A] = wd;
    doResetInit(1);
    doTxn(1, PPI_PORT_A, 1'b0, 8'h00);
    doTxn(0, PPI_PORT_B, 1'b1, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ppi_bus_sequencer.md
Name: ppi_bus_sequencer

Overview:
- Clocked host-side controller for the 8255-style PPI. Shares the PPI bus between two requesters using round-robin arbitration.
- Converts each single-cycle-granted transaction into a timed chip-select/address/strobe sequence on cs_low, A1/A0, RD_low/WR_low and data_buffer.
- After reset, optionally writes a configurable control word. Keeps a shadow copy of the last mode control word.

Parameters:
- SETUP_CYC, 1, cycles cs_low/address are valid before the strobe (1..15)
- STROBE_CYC, 2, cycles RD_low/WR_low are held low (1..15)
- HOLD_CYC, 1, cycles cs_low/address/write data are held after the strobe (1..15)
- INIT_EN, 1, 1 = issue an automatic control-word write after reset
- INIT_CW, 8'h80, control word written by the init sequence (mode 0, all ports output)

Ports:
- clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 request; hold high with stable addr0/we0/wdata0 until done0
- addr0  in  2  requester 0 address {A1,A0}: 00 port A, 01 port B, 10 port C, 11 control
- we0  in  1  1 = write, 0 = read
- wdata0  in  8  requester 0 write data
- done0  out  1  one-cycle completion pulse for requester 0
- req1/addr1/we1/wdata1/done1  same as above, for requester 1
- rdata  out  8  read data; valid while done0 or done1 is high, held until the next read
- busy  out  1  high whenever state is not IDLE
- cw_shadow  out  8  last control word written with bit7 = 1
- cs_low  out  1  PPI chip select, active low
- A0, A1  out  1 each  PPI address
- RD_low, WR_low  out  1 each  PPI strobes, active low
- data_buffer  inout  8  PPI data bus

Behaviour:
- Reset values (applied on the next rising clk edge while Reset = 1):
  - cs_low = RD_low = WR_low = 1; A0 = A1 = 0; data_buffer = z
  - done0 = done1 = 0; rdata = 0; cw_shadow = 8'h9B (the PPI's reset control word); busy = 1 if INIT_EN = 1, else 0
  - Round-robin pointer favours requester 0.
- States: INIT, IDLE, SETUP, STROBE, HOLD, DONE.
  - The state after reset is INIT if INIT_EN = 1, otherwise IDLE.
  - INIT loads an internal transaction (addr = 11, write, INIT_CW), then enters SETUP.
  - A transaction started from INIT raises no done pulse.
- IDLE:
  - On any req high, the arbiter grants one requester and latches its addr/we/wdata. The next state is SETUP.
  - If both requests are high, the requester not served last wins.
- SETUP (SETUP_CYC cycles): cs_low = 0; A1/A0 = latched address; strobes high.
- STROBE (STROBE_CYC cycles):
  - cs_low = 0; RD_low = 0 for a read, WR_low = 0 for a write.
  - For a read, rdata captures data_buffer on the edge that ends the last STROBE cycle.
- HOLD (HOLD_CYC cycles): cs_low = 0; address held; both strobes high.
- DONE (1 cycle):
  - cs_low = 1; A1/A0 = 0; done of the granted requester = 1. The next state is IDLE.
  - A requester must drop req on the edge that ends its done cycle; otherwise a new identical transaction starts.
- Latency: done arrives SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 cycles after the IDLE acceptance edge (5 with defaults). Back-to-back grant period is 6 cycles.
- Data bus: data_buffer is driven with the latched write data only during SETUP, STROBE and HOLD of a write. It is z at all other times.
- Invariant: RD_low and WR_low are never low together. Both strobes are high whenever cs_low = 1.
- cw_shadow update: when a write to addr 11 with data[7] = 1 completes in HOLD, cw_shadow takes that data. BSR writes (data[7] = 0) leave cw_shadow unchanged.
- Phase counters: 4-bit down-counters, reloaded on every phase entry.
- Reset during a transaction: the transaction is abandoned with no done pulse. Outputs return to their reset values on that edge, and INIT repeats.
- A request on an unrequested port, or a change of inputs mid-transaction, is ignored because the transaction uses only the values latched at grant.

Decomposition:
- Shared package ppi_pkg holds:
  - state enum
  - address constants PPI_PORT_A = 2'b00, PPI_PORT_B = 2'b01, PPI_PORT_C = 2'b10, PPI_CTRL = 2'b11
  - PPI_RESET_CW = 8'h9B
- One sub-module, ppi_rr_arbiter: two-way round-robin arbiter with a grant-strobe input that updates the priority pointer.

Test Plan:
- Init write: Reset for 2 cycles, INIT_EN = 1, INIT_CW = 8'h80 → A1A0 = 11 with cs_low low for 4 cycles and WR_low low for 2 cycles; data_buffer = 8'h80 during the write; cw_shadow becomes 8'h80; no done pulse.
- Port A write: req0 with addr 00, we = 1, wdata 8'h01 → WR_low low for exactly 2 cycles with data_buffer = 8'h01; done0 pulses 5 cycles after acceptance; RD_low stays high throughout.
- Port C read: a model drives data_buffer = 8'hA5 while RD_low is low; req1 with addr 10, we = 0 → rdata = 8'hA5 with done1; data_buffer is z from the sequencer side throughout.
- Contention: req0 and req1 both held high → grants alternate 0, 1, 0, 1 with one done per grant; neither requester is starved.
- BSR write: addr 11, wdata 8'h07 after cw_shadow = 8'h80 → cw_shadow stays 8'h80. Then write 8'h9B → cw_shadow becomes 8'h9B.
- Reset in STROBE: Reset asserted while WR_low is low → on the next edge WR_low = 1, cs_low = 1, data_buffer = z, no done; INIT sequence re-runs.
